// File: rtl/mem_responder.sv
// mem_responder
// Word-addressed memory responder for the core's request/response memory
// port. One request is accepted at a time over a valid/ready handshake, the
// block waits LATENCY cycles, commits the store (or reads the word) and
// returns a single-cycle response pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present on req_*
//   req_ready  request can be accepted this cycle (IDLE and not in reset)
//   req_we     1 = store, 0 = load/fetch
//   req_addr   byte address, bits [1:0] ignored
//   req_wdata  store data, little-endian byte lanes
//   req_be     store byte enables, bit i selects lane i
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data (0 for stores and out-of-range accesses)
//   rsp_err    address outside the array
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [29:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic          accept_s;
    logic          commit_s;
    logic          op_we_s;
    logic [29:0]   op_addr_s;
    logic [31:0]   op_wdata_s;
    logic [3:0]    op_be_s;
    logic [AW-1:0] op_idx_s;
    logic          op_err_s;
    logic [31:0]   rd_word_s;
    logic          unused_addr_s;

    // Replace the byte lanes selected by be with the new data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Any word-address bit above the index field set means out of range.
    function automatic logic out_of_range(input logic [29:0] waddr);
        return (waddr >> AW) != 30'd0;
    endfunction

    assign req_ready     = (state_r == IDLE) && !rst;
    assign unused_addr_s = ^req_addr[1:0];

    // Select the operation being committed: with zero latency the commit
    // happens on the accepting edge, so the live request is used directly.
    always_comb begin
        accept_s   = req_valid && req_ready;
        op_we_s    = we_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        op_be_s    = be_r;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                op_we_s    = req_we;
                op_addr_s  = req_addr[31:2];
                op_wdata_s = req_wdata;
                op_be_s    = req_be;
                commit_s   = accept_s && (LAT_C == 4'd0);
            end
            WAIT: begin
                commit_s = (cnt_r == 4'd1);
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
        op_idx_s  = op_addr_s[AW-1:0];
        op_err_s  = out_of_range(op_addr_s);
        rd_word_s = mem_r[op_idx_s];
    end

    // Control FSM, request capture and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            addr_r    <= 30'd0;
            wdata_r   <= 32'd0;
            be_r      <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= commit_s;
            rsp_err   <= commit_s && op_err_s;
            rsp_rdata <= (commit_s && !op_we_s && !op_err_s) ? rd_word_s : 32'd0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r    <= req_we;
                        addr_r  <= req_addr[31:2];
                        wdata_r <= req_wdata;
                        be_r    <= req_be;
                        cnt_r   <= LAT_C;
                        state_r <= (LAT_C == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                    end
                    cnt_r <= cnt_r - 4'd1;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Storage array; not reset. A commit cannot occur while rst is high
    // because the state is forced to IDLE and req_ready is held low.
    always_ff @(posedge clk) begin
        if (commit_s && op_we_s && !op_err_s) begin
            mem_r[op_idx_s] <= merge_lanes(rd_word_s, op_wdata_s, op_be_s);
        end
    end

endmodule
